// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants: format codes, opcodes and immediate range
// limits, plus the decoded field bundle consumed by the encoder.
package rv_isa_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
  localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer: builds the instruction word from decoded fields
// and flags bundles whose immediate cannot be represented in the chosen format.
import rv_isa_pkg::*;

module instr_pack (
  input  fields_t     f,
  output logic [31:0] word,
  output logic        bad
);

  always_comb begin
    word = 32'h0;
    bad  = 1'b0;
    case (f.fmt)
      FMT_R: begin
        word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      end
      FMT_I: begin
        word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
        bad  = !in_range(f.imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
        bad  = !in_range(f.imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                f.imm[4:1], f.imm[11], f.opcode};
        bad  = !in_range(f.imm, IMMB_MIN, IMMB_MAX) || f.imm[0];
      end
      FMT_U: begin
        word = {f.imm[31:12], f.rd, f.opcode};
        bad  = |f.imm[11:0];
      end
      FMT_J: begin
        word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
        bad  = !in_range(f.imm, IMMJ_MIN, IMMJ_MAX) || f.imm[0];
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming encoder: field bundles in, addressed instruction words out, 1-cycle latency.
// Input stalls while a word is held unconsumed; rejected bundles are consumed and pulse err.
import rv_isa_pkg::*;

module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              full
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  logic [1:0]        state;
  logic [ADDR_W-1:0] next_addr;
  fields_t           fields;
  logic [31:0]       word;
  logic              bad;
  logic              accept;

  assign fields = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                    rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  instr_pack u_pack (
    .f    (fields),
    .word (word),
    .bad  (bad)
  );

  // start takes the cycle so a bundle presented alongside it is never accepted
  assign in_ready = (state == ST_RUN) && !start && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      next_addr <= BASE;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_addr  <= BASE;
      err       <= 1'b0;
      err_cnt   <= 8'h0;
      full      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (start) begin
        state     <= ST_RUN;
        next_addr <= BASE;
        out_valid <= 1'b0;
        err_cnt   <= 8'h0;
        full      <= 1'b0;
      end else begin
        if (out_valid && out_ready)
          out_valid <= 1'b0;
        if (accept) begin
          if (bad) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end else begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_addr  <= next_addr;
            next_addr <= next_addr + 1'b1;
            // last address used: stop accepting until the next start
            if (next_addr == LAST) begin
              state <= ST_FULL;
              full  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a scoreboard of expected words/addresses.
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_fmt;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [AW-1:0] out_addr;
  logic          err;
  logic [7:0]    err_cnt;
  logic          full;

  typedef struct packed {
    logic [31:0]   data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          q[$];
  logic [AW-1:0] exp_addr;
  int            n_total = 0;
  int            n_bad   = 0;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .err(err), .err_cnt(err_cnt), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: every handshake must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_total++;
        assert (q.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_word observed=%h expected=none", out_data);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_addr", 32'(out_addr), 32'(e.addr));
        end
      end
    end
  end

  task automatic put(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string tag, input logic [31:0] exp_word, input logic exp_bad);
    logic got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        if (!exp_bad) begin
          q.push_back('{data: exp_word, addr: exp_addr});
          exp_addr = exp_addr + 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk({tag, "_accepted"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_err"}, 32'(err), 32'(exp_bad));
      chk({tag, "_valid"}, 32'(out_valid), 32'(!exp_bad));
    end
  endtask

  task automatic send(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] exp_word, input logic exp_bad);
    put(fmt, op, rd, rs1, rs2, f3, f7, imm);
    wait_accept(tag, exp_word, exp_bad);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; exp_addr = '0;
    put(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // IDLE: nothing accepted before start
    put(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    repeat (2) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Basic encodings
    pulse_start();
    send("addi", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    send("sw",   3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0);
    send("add",  3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0);
    idle(2);
    pulse_start();
    send("beq",  3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h00208463, 1'b0);
    send("jal",  3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 1'b0);
    send("lui",  3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    idle(2);

    // Rejections and range boundaries
    pulse_start();
    send("i_2048", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0, 1'b1);
    chk("err_cnt_1", 32'(err_cnt), 32'd1);
    send("i_5",    3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    send("i_m2048", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
    send("b_7",    3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 32'h0, 1'b1);
    send("u_odd",  3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h0, 1'b1);
    send("fmt6",   3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0, 1'b1);
    chk("err_cnt_4", 32'(err_cnt), 32'd4);
    idle(2);

    // Backpressure: second bundle waits, held word stays stable
    pulse_start();
    chk("start_clears_err_cnt", 32'(err_cnt), 32'd0);
    out_ready = 1'b0;
    send("bp_a", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    put(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", out_data, 32'h00500093);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_accept("bp_b", 32'h002081B3, 1'b0);
    idle(2);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // FULL: four words fill the address space
    pulse_start();
    send("f0", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    send("f1", 3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500113, 1'b0);
    send("f2", 3'd1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500193, 1'b0);
    send("f3", 3'd1, 7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500213, 1'b0);
    chk("full_set", 32'(full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    put(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("full_blocks", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("full_drained", 32'(q.size()), 32'd0);
    pulse_start();
    chk("full_cleared", 32'(full), 32'd0);
    wait_accept("after_full", 32'h002081B3, 1'b0);
    idle(2);

    // start drops a pending word
    out_ready = 1'b0;
    send("drop", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    pulse_start();
    chk("start_drops_valid", 32'(out_valid), 32'd0);
    q.delete();

    // Asynchronous reset with a word pending
    send("pre_rst", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_addr", 32'(out_addr), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    put(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    repeat (2) begin
      @(negedge clk);
      chk("arst_idle", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("final_sb_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
